// File: rtl/sc_mul_job_ctrl.sv
// sc_mul_job_ctrl
//   Job sequencer for the stochastic serial multiplier. Accepts one operand
//   pair per job, pulses the multiplier reset for one cycle, enables the
//   multiplier until it reports done (or a watchdog expires), captures the
//   count and offers it downstream.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake, in_a/in_b operands
//   out_valid/out_ready      result handshake, out_res count, out_err abort flag
//   mul_rst, mul_en          multiplier control
//   mul_a, mul_b             operands held for the multiplier
//   mul_res, mul_done        multiplier count and completion level
module sc_mul_job_ctrl #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned RES_W   = 8,
    parameter int unsigned TIMEOUT = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_res,
    output logic              out_err,
    output logic              mul_rst,
    output logic              mul_en,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [RES_W-1:0]  mul_res,
    input  logic              mul_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [15:0]         r_wd;
    logic                r_err;
    logic [RES_W-1:0]    r_res;
    logic                r_out_err;
    logic                w_accept;
    logic                w_timeout;
    logic                w_run_exit;

    // in_ready is gated by rst so nothing is accepted on a reset cycle
    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_timeout  = (r_wd == WD_LAST);
    assign w_run_exit = mul_done || w_timeout;

    assign out_valid  = (r_state == S_HOLD);
    assign out_res    = r_res;
    assign out_err    = r_out_err;
    assign mul_rst    = rst || (r_state == S_CLEAR);
    assign mul_en     = (r_state == S_RUN);
    assign mul_a      = r_a;
    assign mul_b      = r_b;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next = S_CLEAR;
            S_CLEAR:                 w_next = S_RUN;
            S_RUN:   if (w_run_exit) w_next = S_DRAIN;
            S_DRAIN:                 w_next = S_HOLD;
            S_HOLD:  if (out_ready)  w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_wd      <= '0;
            r_err     <= 1'b0;
            r_res     <= '0;
            r_out_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a <= in_a;
                        r_b <= in_b;
                    end
                end
                S_CLEAR: begin
                    r_wd <= '0;
                end
                S_RUN: begin
                    if (r_wd != '1) r_wd <= r_wd + 16'd1;
                    // done has priority over a coincident timeout
                    if (w_run_exit) r_err <= !mul_done;
                end
                S_DRAIN: begin
                    // one cycle after RUN so the last enabled increment has landed
                    r_res     <= mul_res;
                    r_out_err <= r_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mul_job_ctrl.sv
// tb_sc_mul_job_ctrl
//   Directed bench for sc_mul_job_ctrl with a behavioural multiplier stub.
//   The stub counts enabled cycles; done is high once done_at-1 enabled
//   edges have happened, and the result reads a*b after done_at edges,
//   otherwise the raw enabled-cycle count (the "partial count").
module tb_sc_mul_job_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic       out_err;
    logic       mul_rst;
    logic       mul_en;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [7:0] mul_res;
    logic       mul_done;

    int errors = 0;
    int checks = 0;

    int   done_at = 16;
    logic no_done = 1'b0;
    logic [7:0] s_cnt;

    always #5 clk = ~clk;

    sc_mul_job_ctrl #(
        .DATA_W  (4),
        .RES_W   (8),
        .TIMEOUT (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err),
        .mul_rst   (mul_rst),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res),
        .mul_done  (mul_done)
    );

    // multiplier stub
    always @(posedge clk) begin
        if (mul_rst)                      s_cnt <= 8'd0;
        else if (mul_en && s_cnt != 8'hFF) s_cnt <= s_cnt + 8'd1;
    end
    assign mul_done = !no_done && (int'(s_cnt) >= done_at - 1);
    assign mul_res  = (!no_done && int'(s_cnt) >= done_at)
                    ? ({4'd0, mul_a} * {4'd0, mul_b}) : s_cnt;

    // Offers one pair, waits for acceptance, then counts until out_valid.
    // lat = edges after the accept edge until out_valid is seen (-1 if never).
    task automatic run_job(input logic [3:0] a, input logic [3:0] b,
                           output int lat, output int ens, output int rsts);
        int w;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rsts = mul_rst ? 1 : 0;
        ens  = 0;
        lat  = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mul_en)  ens++;
            if (mul_rst) rsts++;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_a = 4'd9; in_b = 4'd9; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_res !== 8'd0) begin errors++; $display("FAIL reset_out_res: got %0d want 0", out_res); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst: got %b want 1", mul_rst); end
        checks++; if (mul_en !== 1'b0) begin errors++; $display("FAIL reset_mul_en: got %b want 0", mul_en); end
        checks++; if ({mul_a, mul_b} !== 8'd0) begin errors++; $display("FAIL reset_mul_ab: got %0d/%0d want 0/0", mul_a, mul_b); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        checks++; if (mul_rst !== 1'b0) begin errors++; $display("FAIL release_mul_rst: got %b want 0", mul_rst); end
    endtask

    task automatic test_basic;
        int lat, ens, rsts;
        out_ready = 1'b1;
        run_job(4'd3, 4'd5, lat, ens, rsts);
        checks++; if (lat !== 18) begin errors++; $display("FAIL basic_latency: got %0d want 18", lat); end
        checks++; if (ens !== 16) begin errors++; $display("FAIL basic_en_cycles: got %0d want 16", ens); end
        checks++; if (rsts !== 1) begin errors++; $display("FAIL basic_rst_pulses: got %0d want 1", rsts); end
        checks++; if (out_res !== 8'd15) begin errors++; $display("FAIL basic_res: got %0d want 15", out_res); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", out_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_return_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure;
        int lat, ens, rsts;
        logic ok;
        out_ready = 1'b0;
        run_job(4'd3, 4'd5, lat, ens, rsts);
        checks++; if (lat !== 18) begin errors++; $display("FAIL bp_latency: got %0d want 18", lat); end
        in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_res !== 8'd15 || out_err !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_hold_stable: got ok=%b want 1", ok); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_return_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int rcnt, nres, t0, t1;
        logic [7:0] r0, r1;
        logic e0, e1;
        rcnt = 0; nres = 0; t0 = 0; t1 = 0; r0 = '1; r1 = '1; e0 = 1'b1; e1 = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_a = 4'd15; in_b = 4'd15; in_valid = 1'b1;
        for (int cyc = 0; cyc < 120 && nres < 2; cyc++) begin
            @(negedge clk);
            if (mul_rst) begin
                rcnt++;
                if (rcnt == 1) begin in_a = 4'd0; in_b = 4'd7; end
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (nres == 0) begin r0 = out_res; e0 = out_err; t0 = cyc; end
                else begin r1 = out_res; e1 = out_err; t1 = cyc; end
                nres++;
            end
        end
        in_valid = 1'b0;
        checks++; if (nres !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", nres); end
        checks++; if (r0 !== 8'd225 || e0 !== 1'b0) begin errors++; $display("FAIL b2b_first: got %0d err=%b want 225 err=0", r0, e0); end
        checks++; if (r1 !== 8'd0 || e1 !== 1'b0) begin errors++; $display("FAIL b2b_second: got %0d err=%b want 0 err=0", r1, e1); end
        checks++; if (rcnt !== 2) begin errors++; $display("FAIL b2b_rst_pulses: got %0d want 2", rcnt); end
        checks++; if (t1 - t0 !== 20) begin errors++; $display("FAIL b2b_spacing: got %0d want 20", t1 - t0); end
    endtask

    task automatic test_watchdog;
        int lat, ens, rsts;
        no_done = 1'b1;
        run_job(4'd9, 4'd9, lat, ens, rsts);
        checks++; if (ens !== 20) begin errors++; $display("FAIL wd_run_cycles: got %0d want 20", ens); end
        checks++; if (lat !== 22) begin errors++; $display("FAIL wd_latency: got %0d want 22", lat); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL wd_err: got %b want 1", out_err); end
        checks++; if (out_res !== 8'd20) begin errors++; $display("FAIL wd_partial: got %0d want 20", out_res); end
        @(negedge clk);
        no_done = 1'b0;
    endtask

    task automatic test_simultaneous;
        int lat, ens, rsts;
        done_at = 20;
        run_job(4'd2, 4'd3, lat, ens, rsts);
        checks++; if (ens !== 20) begin errors++; $display("FAIL sim_run_cycles: got %0d want 20", ens); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL sim_err: got %b want 0", out_err); end
        checks++; if (out_res !== 8'd6) begin errors++; $display("FAIL sim_res: got %0d want 6", out_res); end
        @(negedge clk);
        done_at = 16;
    endtask

    task automatic test_stale_done;
        int lat, ens, rsts;
        @(negedge clk);
        checks++; if (mul_done !== 1'b1) begin errors++; $display("FAIL stale_precondition: got %b want 1", mul_done); end
        run_job(4'd4, 4'd4, lat, ens, rsts);
        checks++; if (ens !== 16) begin errors++; $display("FAIL stale_run_cycles: got %0d want 16", ens); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL stale_latency: got %0d want 18", lat); end
        checks++; if (out_res !== 8'd16) begin errors++; $display("FAIL stale_res: got %0d want 16", out_res); end
    endtask

    task automatic test_reset_mid_job;
        int lat, ens, rsts, en, w;
        logic seen;
        @(negedge clk);
        in_a = 4'd6; in_b = 4'd6; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        en = 0;
        for (int k = 0; k < 40 && en < 8; k++) begin
            @(negedge clk);
            if (mul_en) en++;
        end
        checks++; if (en !== 8) begin errors++; $display("FAIL mid_reach_run8: got %0d want 8", en); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || mul_rst !== 1'b1) begin
            errors++; $display("FAIL mid_during_rst: got ready=%b valid=%b mrst=%b want 0/0/1", in_ready, out_valid, mul_rst);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid || mul_en) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_result: got activity=%b want 0", seen); end
        run_job(4'd2, 4'd2, lat, ens, rsts);
        checks++; if (out_res !== 8'd4 || lat !== 18) begin
            errors++; $display("FAIL mid_next_job: got res=%0d lat=%0d want 4/18", out_res, lat);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_watchdog;
        test_simultaneous;
        test_stale_done;
        test_reset_mid_job;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_mul_job_ctrl.md
# sc_mul_job_ctrl

Job sequencer that sits directly upstream of the stochastic serial multiplier and also consumes its result. It accepts one operand pair per job over a valid/ready handshake and clears the multiplier for exactly one cycle. It then enables the multiplier until its `done` flag fires, captures the stochastic-to-binary count, and presents that count downstream over a valid/ready handshake. A watchdog aborts jobs whose `done` never arrives.

## Interface
- `DATA_W`, 4: operand width; matches the multiplier's binary inputs.
- `RES_W`, 8: result width; matches the multiplier's counter output.
- `TIMEOUT`, 300: maximum RUN cycles before abort; must be ≥ 2 and fit in 16 bits.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an operand pair is offered.
- `in_ready`  out  1  block accepts a pair this cycle.
- `in_a`, `in_b`  in  `DATA_W`  operands.
- `out_valid`  out  1  result is held on `out_res` / `out_err`.
- `out_ready`  in  1  downstream takes the result.
- `out_res`  out  `RES_W`  captured multiplier count.
- `out_err`  out  1  job aborted by the watchdog; `out_res` holds the partial count.
- `mul_rst`  out  1  synchronous reset to the multiplier.
- `mul_en`  out  1  enable to the multiplier.
- `mul_a`, `mul_b`  out  `DATA_W`  operands to the multiplier.
- `mul_res`  in  `RES_W`  multiplier count output.
- `mul_done`  in  1  multiplier completion flag; level, may stay high.

## Operation
- FSM states are IDLE, CLEAR, RUN, DRAIN and HOLD; the state register resets to IDLE.
- **IDLE**
  - `in_ready`=1.
  - `in_valid`&`in_ready` latches `in_a`/`in_b` into the operand registers and moves to CLEAR.
- **CLEAR**
  - `mul_rst`=1 for exactly one cycle; `mul_en`=0.
  - The watchdog counter loads 0.
  - Next state is RUN.
- **RUN**
  - `mul_en`=1 and the watchdog increments every cycle.
  - `mul_done` sampled high moves to DRAIN with the error flag cleared.
  - Otherwise, when the watchdog equals `TIMEOUT`-1, the FSM moves to DRAIN with the error flag set.
  - If `mul_done` and the timeout hit in the same cycle, `mul_done` wins and `out_err`=0.
- **DRAIN**
  - `mul_en`=0; `mul_res` is registered into `out_res` and the error flag into `out_err`.
  - This cycle lets the final counter increment from the last RUN edge land before capture.
  - Next state is HOLD.
- **HOLD**
  - `out_valid`=1, with `out_res`/`out_err` stable.
  - `out_valid`&`out_ready` returns to IDLE.
  - `in_ready`=0 in HOLD; there is no job overlap.
- **Multiplier outputs**
  - `mul_a`/`mul_b` always drive the operand registers and stay stable from CLEAR through DRAIN.
  - `mul_rst` = `rst` OR (state==CLEAR).
  - `mul_en` is high only in RUN.
- Widths are pass-through; the block does no arithmetic on results. The watchdog counter is 16 bits and saturates (cannot wrap in RUN).
- `mul_done` is ignored outside RUN. A `mul_done` left high from a previous job is cleared by the CLEAR cycle before RUN samples it.

## Timing
- **Reset values**
  - `in_ready`=0 while `rst`=1 (gated), 1 on the first cycle after release.
  - `out_valid`=0, `out_res`=0, `out_err`=0.
  - `mul_rst`=1, `mul_en`=0, `mul_a`=`mul_b`=0.
- **Latency:** accept at edge E0; CLEAR during cycle E0→E1; RUN from E1 for N cycles, where `mul_done` is first high in the Nth RUN cycle; DRAIN one cycle; `out_valid` rises N+2 cycles after E0.
- **Throughput:** one job per N+4 cycles at minimum, with `out_ready` held high.
- **Reset mid-job (any state):** the job is abandoned without emitting a result; `out_valid` drops on the next edge and the FSM returns to IDLE.
- **Input-side rule:** `in_valid` may be asserted anytime; the pair is held by the source until accepted. A pair offered while not in IDLE is not consumed.
- **Output-side rule:** `out_res`/`out_err` must not change while `out_valid`=1 and `out_ready`=0.

## Test plan
- **Basic job.** Use a behavioural multiplier stub: `mul_res`=a·b after 16 enabled cycles, then `done`. Offer a=3, b=5 → exactly one `mul_rst` pulse; `mul_en` high 16 cycles; `out_valid` at E0+18; `out_res`=15, `out_err`=0.
- **Output backpressure.** Same job with `out_ready`=0 for 10 cycles after `out_valid` → `out_res`=15 stable; `in_ready`=0 throughout HOLD; return to IDLE on the first cycle with `out_ready`=1.
- **Back-to-back jobs.** Keep `in_valid` and `out_ready` high and send (15,15) then (0,7) → results 225 then 0, in order, each job preceded by its own `mul_rst` pulse.
- **Watchdog abort.** Stub never asserts `done`, `TIMEOUT`=20 → exactly 20 RUN cycles; `out_valid` with `out_err`=1 and `out_res` equal to the stub's partial count.
- **Simultaneous events.**
  - `done` arrives in the same cycle the watchdog reaches `TIMEOUT`-1 → `out_err`=0.
  - A stale `done` held high into the next job → no early exit; RUN still lasts the full 16 cycles.
- **Reset mid-job.** Assert `rst` for 1 cycle at RUN cycle 8 → no `out_valid` for that job; `in_ready`=1 one cycle after release; the next job (2,2) returns 4.
